// File: rtl/shift_normalizer_pkg.sv
// Shared types for shift_normalizer: FSM state encoding and direction codes.
package shift_normalizer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_normalizer.sv
// Iterative normalizer: shifts a captured word one bit per cycle until its MSB (left) or LSB
// (right) is set. Optional result counter is enabled by defining SHIFT_NORMALIZER_STATS_EN.
module shift_normalizer
  import shift_normalizer_pkg::*;
#(
  parameter int unsigned bit_size = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [bit_size-1:0]         data,
  input  logic                        direction,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [bit_size-1:0]         out,
  output logic [$clog2(bit_size)-1:0] num_shift,
  output logic                        zero
`ifdef SHIFT_NORMALIZER_STATS_EN
  ,
  output logic [15:0]                 result_count
`endif
);

  localparam int unsigned CntW = $clog2(bit_size);

  state_e              state_q, state_d;
  logic [bit_size-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic                zero_q, zero_d;
  logic                target_set;
  logic                finished;

  assign target_set = (dir_q == DIR_LEFT) ? shreg_q[bit_size-1] : shreg_q[0];
  // A zero word can never reach the target bit, so it terminates immediately.
  assign finished   = (shreg_q == '0) || target_set;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (finished) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    zero_d  = zero_q;
    if (state_q == IDLE && in_valid) begin
      shreg_d = data;
      dir_d   = direction;
      cnt_d   = '0;
      zero_d  = (data == '0);
    end else if (state_q == SHIFT && !finished) begin
      shreg_d = (dir_q == DIR_LEFT) ? (shreg_q << 1) : (shreg_q >> 1);
      cnt_d   = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_LEFT;
      zero_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
    end
  end

  assign out       = shreg_q;
  assign num_shift = cnt_q;
  assign zero      = zero_q;

`ifdef SHIFT_NORMALIZER_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (state_q == DONE && out_ready && count_q != 16'hFFFF) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign result_count = count_q;
`endif

endmodule
